// File: rtl/pc_seq_pkg.sv
// Shared types and reset constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    BR_SEQ     = 3'd0,
    BR_REL_IMM = 3'd1,
    BR_REL_LUT = 3'd2,
    BR_ABS_LUT = 3'd3,
    BR_CALL    = 3'd4,
    BR_RET     = 3'd5,
    BR_HALT    = 3'd6,
    BR_RSVD    = 3'd7
  } br_op_t;

  localparam int PC_RESET  = 0;
  localparam int LUT_RESET = 0;

endpackage

// File: rtl/return_stack.sv
// Hardware LIFO of return addresses. Pushes when full and pops when empty are
// dropped here so the caller only has to flag them.
module return_stack #(
  parameter  int D   = 12,
  parameter  int RSD = 4,
  localparam int DW  = $clog2(RSD + 1),
  localparam int AW  = (RSD > 1) ? $clog2(RSD) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [D-1:0]  push_data,
  output logic [D-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] depth
);

  logic [D-1:0]  mem [RSD];
  logic [DW-1:0] depth_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (depth_q == DW'(RSD));
  assign empty   = (depth_q == '0);
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~empty;
  assign depth   = depth_q;
  assign top     = mem[AW'(depth_q - DW'(1))];

  // NOTE: non-blocking assignments in every clocked block, so all state
  // updated on one edge sees the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
    end else if (do_push) begin
      depth_q <= depth_q + DW'(1);
    end else if (do_pop) begin
      depth_q <= depth_q - DW'(1);
    end
  end

  // NOTE: stack storage is deliberately not reset; depth_q guards every read,
  // so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[AW'(depth_q)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, runtime-writable branch-target LUT,
// next-PC selection, return stack and sticky status flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D   = 12,
  parameter int IW  = 4,
  parameter int RSD = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       stall,
  input  logic [2:0]                 br_op,
  input  logic                       br_taken,
  input  logic [IW-1:0]              br_idx,
  input  logic                       lut_we,
  input  logic [IW-1:0]              lut_waddr,
  input  logic [D-1:0]               lut_wdata,
  output logic [D-1:0]               prog_ctr,
  output logic                       done,
  output logic [$clog2(RSD+1)-1:0]   rs_depth,
  output logic                       rs_overflow,
  output logic                       rs_underflow
);

  localparam int LUT_N = 2 ** IW;

  logic [D-1:0] lut [LUT_N];
  logic [D-1:0] lut_rd;
  logic [D-1:0] imm_ext;
  logic [D-1:0] pc_plus1;
  logic [D-1:0] pc_next;
  logic [D-1:0] rs_top;
  logic         rs_full;
  logic         rs_empty;
  logic         advance;
  logic         push;
  logic         pop;
  logic         halt;
  br_op_t       op;

  assign op       = br_op_t'(br_op);
  assign advance  = ~done & ~stall;
  assign lut_rd   = lut[br_idx];
  assign imm_ext  = D'($signed(br_idx));
  assign pc_plus1 = prog_ctr + D'(1);

  // NOTE: every always_comb output gets a default up front so no path can
  // infer a latch.
  always_comb begin
    pc_next = prog_ctr;
    push    = 1'b0;
    pop     = 1'b0;
    halt    = 1'b0;
    if (advance) begin
      case (op)
        BR_REL_IMM: pc_next = br_taken ? prog_ctr + imm_ext : pc_plus1;
        BR_REL_LUT: pc_next = br_taken ? prog_ctr + lut_rd : pc_plus1;
        BR_ABS_LUT: pc_next = br_taken ? lut_rd : pc_plus1;
        BR_CALL: begin
          pc_next = lut_rd;
          push    = 1'b1;
        end
        BR_RET: begin
          pc_next = rs_empty ? pc_plus1 : rs_top;
          pop     = 1'b1;
        end
        BR_HALT: halt    = 1'b1;
        default: pc_next = pc_plus1;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prog_ctr     <= D'(PC_RESET);
      done         <= 1'b0;
      rs_overflow  <= 1'b0;
      rs_underflow <= 1'b0;
    end else begin
      prog_ctr <= pc_next;
      if (halt)             done         <= 1'b1;
      if (push && rs_full)  rs_overflow  <= 1'b1;
      if (pop && rs_empty)  rs_underflow <= 1'b1;
    end
  end

  // Writes land at the edge, so a same-cycle read of that index sees the old entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        lut[i] <= D'(LUT_RESET);
      end
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  return_stack #(
    .D   (D),
    .RSD (RSD)
  ) u_return_stack (
    .clk       (Clk),
    .rst       (Reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus1),
    .top       (rs_top),
    .full      (rs_full),
    .empty     (rs_empty),
    .depth     (rs_depth)
  );

endmodule
